// File: rtl/bht_gshare.sv
// Gshare/bimodal branch history table: per-row saturating counters for every
// fetch slot, a speculative global history register, and a flush sweep FSM.
module bht_gshare #(
    parameter int unsigned VLEN            = 64,
    parameter int unsigned NR_ROWS         = 64,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned HIST_LEN        = 6,
    parameter int unsigned OFFSET          = 1,
    parameter bit          GSHARE_EN       = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_bp_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       spec_push_i,
    input  logic                       spec_taken_i,
    input  logic                       update_valid_i,
    input  logic [VLEN-1:0]            update_pc_i,
    input  logic                       update_taken_i,
    input  logic                       update_mispredict_i,
    input  logic [HIST_LEN-1:0]        update_hist_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    output logic [HIST_LEN-1:0]        pred_hist_o,
    output logic                       ready_o
);

    localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
    localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned COL_W    = (COL_BITS > 0) ? COL_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(NR_ROWS - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    // Row index, optionally hashed with a history value zero-extended to ROW_BITS
    function automatic logic [ROW_BITS-1:0] f_row(input logic [VLEN-1:0] pc,
                                                  input logic [HIST_LEN-1:0] hist);
        logic [ROW_BITS-1:0] row;
        row = ROW_BITS'(pc >> (OFFSET + COL_BITS));
        if (GSHARE_EN) row = row ^ ROW_BITS'(hist);
        return row;
    endfunction

    // Slot within the row; a single-slot table always uses column 0
    function automatic logic [COL_W-1:0] f_col(input logic [VLEN-1:0] pc);
        if (COL_BITS == 0) return '0;
        return COL_W'(pc >> OFFSET);
    endfunction

    // Saturating up/down counter step, clamped at 0 and all-ones
    function automatic logic [CTR_BITS-1:0] f_sat(input logic [CTR_BITS-1:0] ctr,
                                                  input logic up);
        if (up)  return (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1);
        return (ctr == '0) ? ctr : ctr - CTR_BITS'(1);
    endfunction

    logic                r_valid [NR_ROWS][INSTR_PER_FETCH];
    logic [CTR_BITS-1:0] r_ctr   [NR_ROWS][INSTR_PER_FETCH];
    logic [HIST_LEN-1:0] r_ghr;
    logic [HIST_LEN-1:0] w_ghr_d;
    state_t              r_state;
    state_t              w_state_d;
    logic [ROW_BITS-1:0] r_sweep;
    logic [ROW_BITS-1:0] w_sweep_d;
    logic                w_ready;
    logic                w_upd_en;
    logic [ROW_BITS-1:0] w_urow;
    logic [COL_W-1:0]    w_ucol;
    logic [ROW_BITS-1:0] w_lrow;
    logic                w_unused;

    assign w_ready  = (r_state == S_IDLE);
    // Training is blocked while sweeping and in the cycle flush is raised
    assign w_upd_en = update_valid_i & w_ready & ~flush_bp_i;
    assign w_urow   = f_row(update_pc_i, update_hist_i);
    assign w_ucol   = f_col(update_pc_i);
    assign w_lrow   = f_row(vpc_i, r_ghr);
    assign w_unused = ^{vpc_i, update_pc_i};

    // Sweep FSM state and row counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_d;
            r_sweep <= w_sweep_d;
        end
    end

    // Sweep next-state: flush (re)starts at row 0, last row returns to idle
    always_comb begin
        w_state_d = r_state;
        w_sweep_d = r_sweep;
        case (r_state)
            S_IDLE: begin
                if (flush_bp_i) begin
                    w_state_d = S_CLEAR;
                    w_sweep_d = '0;
                end
            end
            S_CLEAR: begin
                if (flush_bp_i) begin
                    w_sweep_d = '0;
                end else if (r_sweep == ROW_LAST) begin
                    w_state_d = S_IDLE;
                    w_sweep_d = '0;
                end else begin
                    w_sweep_d = r_sweep + ROW_BITS'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_sweep_d = '0;
            end
        endcase
    end

    // History next value: flush, then mispredict repair, then speculative shift
    always_comb begin
        w_ghr_d = r_ghr;
        if (flush_bp_i) begin
            w_ghr_d = '0;
        end else if (update_valid_i && update_mispredict_i && w_ready) begin
            w_ghr_d = HIST_LEN'({update_hist_i, update_taken_i});
        end else if (spec_push_i) begin
            w_ghr_d = HIST_LEN'({r_ghr, spec_taken_i});
        end
    end

    // History register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_ghr <= '0;
        else         r_ghr <= w_ghr_d;
    end

    // Table storage: reset init, one row cleared per sweep cycle, or training
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NR_ROWS; r++) begin
                for (int c = 0; c < INSTR_PER_FETCH; c++) begin
                    r_valid[r][c] <= 1'b0;
                    r_ctr[r][c]   <= CTR_INIT;
                end
            end
        end else if (r_state == S_CLEAR) begin
            for (int c = 0; c < INSTR_PER_FETCH; c++) begin
                r_valid[r_sweep][c] <= 1'b0;
                r_ctr[r_sweep][c]   <= CTR_INIT;
            end
        end else if (w_upd_en) begin
            r_valid[w_urow][w_ucol] <= 1'b1;
            r_ctr[w_urow][w_ucol]   <= f_sat(r_ctr[w_urow][w_ucol], update_taken_i);
        end
    end

    // Lookup reads the registered table, so a same-cycle update is not bypassed
    always_comb begin
        pred_valid_o = '0;
        pred_taken_o = '0;
        for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            pred_valid_o[i] = r_valid[w_lrow][i] & w_ready;
            pred_taken_o[i] = r_ctr[w_lrow][i][CTR_BITS-1];
        end
    end

    assign pred_hist_o = r_ghr;
    assign ready_o     = w_ready;

endmodule

// File: tb/tb_bht_gshare.sv
// Scoreboard bench for bht_gshare with default parameters.
module tb_bht_gshare;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_bp_i;
    logic [63:0] vpc_i;
    logic        spec_push_i;
    logic        spec_taken_i;
    logic        update_valid_i;
    logic [63:0] update_pc_i;
    logic        update_taken_i;
    logic        update_mispredict_i;
    logic [5:0]  update_hist_i;
    logic [1:0]  pred_valid_o;
    logic [1:0]  pred_taken_o;
    logic [5:0]  pred_hist_o;
    logic        ready_o;

    always #5 clk = ~clk;

    bht_gshare dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .flush_bp_i          (flush_bp_i),
        .vpc_i               (vpc_i),
        .spec_push_i         (spec_push_i),
        .spec_taken_i        (spec_taken_i),
        .update_valid_i      (update_valid_i),
        .update_pc_i         (update_pc_i),
        .update_taken_i      (update_taken_i),
        .update_mispredict_i (update_mispredict_i),
        .update_hist_i       (update_hist_i),
        .pred_valid_o        (pred_valid_o),
        .pred_taken_o        (pred_taken_o),
        .pred_hist_o         (pred_hist_o),
        .ready_o             (ready_o)
    );

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // reference model of table and history
    logic [1:0]  m_ctr [64][2];
    logic        m_vld [64][2];
    logic [5:0]  m_ghr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_o(input int kind, input logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       chk("pred_valid", 32'(pred_valid_o), e.exp);
                1:       chk("pred_taken", 32'(pred_taken_o), e.exp);
                2:       chk("pred_hist",  32'(pred_hist_o),  e.exp);
                default: chk("ready",      32'(ready_o),      e.exp);
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int mrow(input logic [63:0] pc, input logic [5:0] h);
        return int'((pc >> 2) & 64'h3f) ^ int'(h);
    endfunction

    function automatic int mcol(input logic [63:0] pc);
        return int'((pc >> 1) & 64'h1);
    endfunction

    function automatic logic [1:0] msat(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    task automatic model_init();
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 2; c++) begin
                m_vld[r][c] = 1'b0;
                m_ctr[r][c] = 2'b10;
            end
        end
        m_ghr = '0;
    endtask

    task automatic model_upd(input logic [63:0] pc, input logic [5:0] h, input logic t);
        int r;
        int c;
        r = mrow(pc, h);
        c = mcol(pc);
        m_vld[r][c] = 1'b1;
        m_ctr[r][c] = msat(m_ctr[r][c], t);
    endtask

    task automatic look(input logic [63:0] pc);
        int r;
        vpc_i = pc;
        r = mrow(pc, m_ghr);
        expect_o(0, {30'd0, m_vld[r][1], m_vld[r][0]});
        expect_o(1, {30'd0, m_ctr[r][1][1], m_ctr[r][0][1]});
        expect_o(2, {26'd0, m_ghr});
        drain();
    endtask

    task automatic upd(input logic [63:0] pc, input logic [5:0] h, input logic t);
        update_valid_i = 1'b1;
        update_pc_i    = pc;
        update_hist_i  = h;
        update_taken_i = t;
        tick();
        update_valid_i = 1'b0;
        model_upd(pc, h, t);
    endtask

    task automatic push(input logic t);
        spec_push_i  = 1'b1;
        spec_taken_i = t;
        tick();
        spec_push_i  = 1'b0;
        m_ghr = {m_ghr[4:0], t};
        expect_o(2, {26'd0, m_ghr});
        drain();
    endtask

    task automatic expect_reset_outputs();
        expect_o(0, 32'd0);
        expect_o(1, 32'd3);
        expect_o(2, 32'd0);
        expect_o(3, 32'd1);
        drain();
    endtask

    logic [9:0] pat;
    int         lowcnt;
    int         badv;
    int         pre_low;

    initial begin
        rst_ni = 1'b0;
        flush_bp_i = 1'b0;
        vpc_i = '0;
        spec_push_i = 1'b0;
        spec_taken_i = 1'b0;
        update_valid_i = 1'b0;
        update_pc_i = '0;
        update_taken_i = 1'b0;
        update_mispredict_i = 1'b0;
        update_hist_i = '0;
        model_init();

        // reset state
        tick();
        tick();
        expect_reset_outputs();
        rst_ni = 1'b1;
        tick();
        look(64'h104);

        // saturation at both ends on row 1 slot 0
        for (int i = 0; i < 4; i++) begin
            upd(64'h104, 6'd0, 1'b0);
            look(64'h104);
        end
        for (int i = 0; i < 4; i++) begin
            upd(64'h104, 6'd0, 1'b1);
            look(64'h104);
        end
        for (int i = 0; i < 2; i++) begin
            upd(64'h104, 6'd0, 1'b0);
            look(64'h104);
        end

        // same-cycle lookup and update: old value first, new value next cycle
        vpc_i = 64'h104;
        update_valid_i = 1'b1;
        update_pc_i = 64'h104;
        update_hist_i = 6'd0;
        update_taken_i = 1'b1;
        look(64'h104);
        tick();
        update_valid_i = 1'b0;
        model_upd(64'h104, 6'd0, 1'b1);
        look(64'h104);

        // speculative history pushes, then mispredict repair beating a push
        pat = 10'b1011001011;
        for (int i = 9; i >= 0; i--) push(pat[i]);
        update_valid_i = 1'b1;
        update_mispredict_i = 1'b1;
        update_pc_i = 64'h300;
        update_hist_i = 6'b000111;
        update_taken_i = 1'b0;
        spec_push_i = 1'b1;
        spec_taken_i = 1'b1;
        tick();
        update_valid_i = 1'b0;
        update_mispredict_i = 1'b0;
        spec_push_i = 1'b0;
        model_upd(64'h300, 6'b000111, 1'b0);
        m_ghr = {6'b000111 << 1};
        look(64'h300);

        // gshare hashing: update row uses update_hist_i, lookup uses ghr
        for (int i = 0; i < 4; i++) push(1'b0);
        push(1'b1);
        push(1'b1);
        upd(64'h000, 6'b000011, 1'b1);
        look(64'h000);
        look(64'h00C);
        for (int i = 0; i < 6; i++) push(1'b0);
        look(64'h00C);
        upd(64'h010, 6'b000010, 1'b0);
        look(64'h018);
        look(64'h010);

        // flush sweep with dropped updates and an honoured spec push
        flush_bp_i = 1'b1;
        update_valid_i = 1'b1;
        update_pc_i = 64'h104;
        update_taken_i = 1'b1;
        expect_o(3, 32'd1);
        drain();
        tick();
        flush_bp_i = 1'b0;
        model_init();
        lowcnt = 0;
        badv = 0;
        while (ready_o === 1'b0 && lowcnt < 200) begin
            update_valid_i = 1'b1;
            update_pc_i = 64'(lowcnt) << 2;
            update_taken_i = lowcnt[0];
            spec_push_i = (lowcnt == 10);
            spec_taken_i = 1'b1;
            #1;
            if (pred_valid_o !== 2'b00) badv++;
            lowcnt++;
            tick();
        end
        update_valid_i = 1'b0;
        spec_push_i = 1'b0;
        chk("sweep_len", 32'(lowcnt), 32'd64);
        chk("sweep_pred_valid", 32'(badv), 32'd0);
        m_ghr = 6'b000001;
        expect_o(2, {26'd0, m_ghr});
        expect_o(3, 32'd1);
        drain();
        for (int i = 0; i < 6; i++) push(1'b0);
        for (int r = 0; r < 64; r++) look(64'(r) << 2);

        // flush re-asserted mid-sweep restarts the full sweep
        flush_bp_i = 1'b1;
        tick();
        flush_bp_i = 1'b0;
        pre_low = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o === 1'b0) pre_low++;
            tick();
        end
        chk("reflush_pre", 32'(pre_low), 32'd40);
        flush_bp_i = 1'b1;
        tick();
        flush_bp_i = 1'b0;
        lowcnt = 0;
        while (ready_o === 1'b0 && lowcnt < 200) begin
            lowcnt++;
            tick();
        end
        chk("reflush_len", 32'(lowcnt), 32'd64);

        // asynchronous reset mid-sweep
        upd(64'h104, 6'd0, 1'b1);
        look(64'h104);
        flush_bp_i = 1'b1;
        tick();
        flush_bp_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_ni = 1'b0;
        expect_reset_outputs();
        rst_ni = 1'b1;
        tick();
        model_init();
        expect_o(3, 32'd1);
        drain();
        look(64'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
